// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// small helpers used by the RTL and by the bench for state checks.
// Optional feature macro: OVERFLOW_FLAG_EN (adds the signed overflow flag).
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;
  // 2'd3 is unused and behaves as S_IDLE.

  // A new request may be taken in any state other than RUN.
  function automatic logic can_accept(input state_t st);
    return st != S_RUN;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake bundle between an issuing master and the
// bit-serial adder. The ovf signal exists only when OVERFLOW_FLAG_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;
`endif

`ifdef OVERFLOW_FLAG_EN
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder cell; the controller reuses this single cell
// once per cycle. Not affected by OVERFLOW_FLAG_EN.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  always_comb begin
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds a + b + cin LSB first through one full
// adder cell over WIDTH cycles, with a start/busy/done handshake.
// Optional feature macro: OVERFLOW_FLAG_EN adds a signed overflow flag (ovf).
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; outputs hold last result
//   RUN    | one operand bit per cycle through the full adder cell
//   DONE   | done pulse, result valid; start here chains a new op
//   (3)    | unused encoding, behaves as IDLE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q;
`endif

  fa_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Request acceptance and last-bit detection.
  always_comb begin
    accept  = bus.start && can_accept(state_q);
    last    = (state_q == S_RUN) && (cnt_q == LAST_BIT);
    res_nxt = {fa_s, res_q};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_RUN:   state_d = last ? S_DONE : S_RUN;
      default: state_d = bus.start ? S_RUN : S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    bus.busy = (state_q == S_RUN);
    bus.done = (state_q == S_DONE);
    bus.sum  = sum_q;
    bus.cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
    bus.ovf  = ovf_q;
`endif
  end

  // Serial datapath: operand capture, per-bit shift, result publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q   <= '0;
      a_sh_q  <= bus.a;
      b_sh_q  <= bus.b;
      carry_q <= bus.cin;
    end else if (state_q == S_RUN) begin
      a_sh_q  <= a_sh_q >> 1;
      b_sh_q  <= b_sh_q >> 1;
      carry_q <= fa_co;
      res_q   <= res_nxt[WIDTH-1:1];
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      if (last) begin
        sum_q  <= res_nxt;
        cout_q <= fa_co;
`ifdef OVERFLOW_FLAG_EN
        // carry_q here is the carry into the MSB position.
        ovf_q  <= carry_q ^ fa_co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8). Honours OVERFLOW_FLAG_EN.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;
  exp_t scb[$];

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        exp_t e;
        done_cnt++;
        chk("done_single_cycle", int'(prev_done), 0);
        chk("busy_len", busy_run, W);
        if (scb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = scb.pop_front();
          chk("sum", int'(bus.sum), int'(e.sum));
          chk("cout", int'(bus.cout), int'(e.cout));
          chk("latency", cyc, e.due);
`ifdef OVERFLOW_FLAG_EN
          chk("ovf", int'(bus.ovf), int'(e.ovf));
`endif
        end
        busy_run = 0;
      end else if (!bus.busy) begin
        busy_run = 0;
      end
      prev_done = bus.done;
    end
  end

  // Reference: whole-word arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ic, input int due);
    exp_t e;
    logic [W:0] t;
    int s;
    t = (W+1)'(ia) + (W+1)'(ib) + (W+1)'(ic);
    s = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
    e.due  = due;
    return e;
  endfunction

  // Drive a request at a negedge where the DUT can accept; push its expectation.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.cin   = ic;
    scb.push_back(model(ia, ib, ic, cyc + 1 + W));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("wait_done_timeout", 1, 0);
  endtask

  initial begin
    int base;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_sum", int'(bus.sum), 0);
    chk("rst_cout", int'(bus.cout), 0);
    chk("rst_state", int'(dut.state_q), int'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    issue(8'h0F, 8'h01, 1'b0); wait_idle();
    issue(8'hFF, 8'h01, 1'b0); wait_idle();
    issue(8'h7F, 8'h01, 1'b0); wait_idle();
    issue(8'h80, 8'h80, 1'b1); wait_idle();
    @(negedge clk);

    // Start held through RUN with other operands must be ignored.
    base = done_cnt;
    issue(8'h00, 8'h00, 1'b1);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    wait_done();
    bus.start = 1'b0;
    repeat (2 * W) @(negedge clk);
    chk("held_start_one_done", done_cnt - base, 1);
    chk("held_start_sum", int'(bus.sum), 8'h01);

    // Reset in the 4th RUN cycle abandons the op.
    issue(8'h33, 8'h44, 1'b0);
    repeat (3) @(negedge clk);
    chk("run_busy_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    bus.start = 1'b1;
    scb.delete();
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_sum", int'(bus.sum), 0);
    chk("midrst_cout", int'(bus.cout), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    base = done_cnt;
    repeat (W + 3) @(negedge clk);
    chk("midrst_no_done", done_cnt - base, 0);

    // Back-to-back: new operands held on start, accepted in DONE.
    base = cyc;
    issue(8'h05, 8'h06, 1'b0);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    wait_done();
    issue(8'h10, 8'h20, 1'b0);
    chk("b2b_reenter_busy", int'(bus.busy), 1);
    wait_idle();
    wait_done();
    @(negedge clk);

    // Randomized traffic, including back-to-back issues from DONE.
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", scb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
